stream_join_sched: RTL and testbench
====================================

Name: stream_join_sched

Overview:
- Descriptor-driven scheduler for the dynamic stream join primitive.
- Accepts join descriptors (input subset mask plus beat count) over a valid/ready port and buffers them in a small FIFO.
- Applies the head descriptor's mask to the join for exactly the requested number of output beats, then retires it and advances to the next.
- Sits between a DMA/PLIC-style control path and N_INP producer streams that must be consumed in lock-step.

Parameters:
- N_INP, 4: number of input streams; must be >= 1.
- DEPTH, 4: descriptor FIFO depth; power of two, >= 2.
- BEATS_W, 8: width of the beat-count field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of FIFO and beat counter.
- desc_sel_i  in  N_INP  input subset mask for the descriptor.
- desc_beats_i  in  BEATS_W  number of beats minus one.
- desc_valid_i  in  1  descriptor valid.
- desc_ready_o  out  1  descriptor ready.
- inp_valid_i  in  N_INP  input stream valids.
- inp_ready_o  out  N_INP  input stream readies.
- oup_valid_o  out  1  joined output valid.
- oup_ready_i  in  1  joined output ready.
- oup_last_o  out  1  current beat is the last beat of the head descriptor.
- busy_o  out  1  head descriptor present.
- fill_o  out  $clog2(DEPTH+1)  number of stored descriptors.
- err_zero_sel_o  out  1  one-cycle pulse when a zero-mask descriptor is discarded.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FIFO is emptied and the beat counter is cleared.
  - fill_o=0, busy_o=0, oup_valid_o=0, inp_ready_o=0, oup_last_o=0, err_zero_sel_o=0.
  - desc_ready_o=1.
- Descriptor FIFO:
  - Registered with no fall-through; desc_ready_o = !full.
  - Push happens on desc_valid_i && desc_ready_o.
  - A push at cycle t makes the descriptor visible at the head at t+1 at the earliest.
  - When full, desc_ready_o=0 even if a pop occurs in the same cycle (no bypass).
  - Simultaneous push and pop in a non-full, non-empty FIFO leaves fill_o unchanged.
- State machine:
  - IDLE: FIFO empty. The join mask is forced to 0, so oup_valid_o=0 and inp_ready_o=0. Moves to ACTIVE when FIFO becomes non-empty.
  - ACTIVE: head descriptor drives the join mask.
  - oup_valid_o = &(inp_valid_i | ~sel) && |sel.
  - inp_ready_o[i] = oup_valid_o & oup_ready_i & sel[i].
  - Each output handshake increments beat_cnt.
  - On a handshake with beat_cnt == head.beats: oup_last_o=1, pop, beat_cnt <= 0. Next state is ACTIVE if another descriptor remains, otherwise IDLE.
  - Back-to-back descriptors are allowed: the new head is applied in the cycle after the pop, with no bubble beyond that registered advance.
- Zero-mask head:
  - No output beat is produced.
  - The descriptor is popped in the first cycle it is at the head.
  - err_zero_sel_o pulses high for that single cycle; beat_cnt stays 0.
- oup_last_o: combinational, = busy_o && beat_cnt == head.beats. It is valid only while oup_valid_o=1.
- Beat counter: BEATS_W bits wide, so at most 2^BEATS_W beats per descriptor. It never wraps, because the pop occurs exactly at the terminal value.
- Ready/valid rules:
  - oup_valid_o never depends on oup_ready_i.
  - Once asserted, oup_valid_o stays high until a handshake, provided the inputs obey the AXI rule and the head is unchanged. The head cannot change without a handshake.
- flush_i:
  - Has priority over push and pop in the same cycle.
  - Next cycle: FIFO empty, beat_cnt=0, state IDLE.
  - During the flush cycle, oup_valid_o and inp_ready_o are forced to 0 and desc_ready_o is forced to 0.
- Reset mid-transfer: asynchronously abandons the head descriptor. The partial beat count is lost and no output beat is emitted.

Decomposition:
- Package stream_join_sched_pkg holds a parameterised descriptor struct builder and the constants FILL_W = $clog2(DEPTH+1) and PTR_W = $clog2(DEPTH).
- Descriptor type: struct {logic [N_INP-1:0] sel; logic [BEATS_W-1:0] beats;}. It is declared locally via a typedef, because the struct depends on module parameters.
- One sub-module: the existing dynamic stream join cell, instantiated with N_INP; its sel_i is driven by the gated head mask.
- FIFO pointers, counter and FSM are written inline.
- Elaboration assertions: N_INP >= 1; DEPTH is a power of two and >= 2.

Test Plan:
- Single descriptor: sel=4'b0101, beats=2; all inputs valid, oup_ready_i=1 → 3 handshakes on consecutive cycles; inp_ready_o=4'b0101 each beat; oup_last_o only on the 3rd; fill_o 1→0; busy_o low afterwards.
- Partial valids: sel=4'b0011, inp_valid_i=4'b0001 → oup_valid_o=0 and inp_ready_o=0; raise bit 1 → handshake on that cycle; unselected input 2 never readied.
- Back-to-back, full FIFO: push 4 descriptors (beats=0, masks 1,2,4,8) → desc_ready_o low at fill_o=4; outputs drain one per cycle after first head; inp_ready_o sequence 0001,0010,0100,1000.
- Zero mask: push sel=0 then sel=4'b1111, beats=0 → err_zero_sel_o single pulse, no beat for the first, then one beat with all four readies.
- Backpressure: sel=4'b1111, beats=1, oup_ready_i=0 for 5 cycles → oup_valid_o held high, inp_ready_o=0, beat_cnt unchanged; release → 2 beats then pop.
- Flush and reset: flush_i mid-descriptor after 1 of 4 beats with push asserted → no push accepted, fill_o=0 next cycle. Assert rst_ni=0 asynchronously mid-burst → outputs at reset values immediately.

Source files
------------

// File: rtl/stream_join_sched_pkg.sv
// Shared types and width helpers for the descriptor-driven stream join scheduler.
package stream_join_sched_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic int calc_fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int calc_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Packed width of a {sel, beats} descriptor for the given parameters.
  function automatic int calc_desc_w(input int n_inp, input int beats_w);
    return n_inp + beats_w;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_join_sched_join.sv
// Dynamic stream join: the selected inputs are consumed together in lock-step.
module stream_join_sched_join #(
  parameter int N_INP = 4
) (
  input  logic [N_INP-1:0] inp_valid_i,
  output logic [N_INP-1:0] inp_ready_o,
  input  logic [N_INP-1:0] sel_i,
  output logic             oup_valid_o,
  input  logic             oup_ready_i
);

  logic w_fire;

  assign oup_valid_o = (&(inp_valid_i | ~sel_i)) && (|sel_i);
  assign w_fire      = oup_valid_o & oup_ready_i;

  for (genvar gi = 0; gi < N_INP; gi++) begin : g_ready
    assign inp_ready_o[gi] = w_fire & sel_i[gi];
  end

endmodule

// File: rtl/stream_join_sched.sv
// Descriptor FIFO plus beat counter that drives the join mask one descriptor at a time.
module stream_join_sched
  import stream_join_sched_pkg::*;
#(
  parameter int N_INP   = 4,
  parameter int DEPTH   = 4,
  parameter int BEATS_W = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [N_INP-1:0]              desc_sel_i,
  input  logic [BEATS_W-1:0]            desc_beats_i,
  input  logic                          desc_valid_i,
  output logic                          desc_ready_o,
  input  logic [N_INP-1:0]              inp_valid_i,
  output logic [N_INP-1:0]              inp_ready_o,
  output logic                          oup_valid_o,
  input  logic                          oup_ready_i,
  output logic                          oup_last_o,
  output logic                          busy_o,
  output logic [calc_fill_w(DEPTH)-1:0] fill_o,
  output logic                          err_zero_sel_o
);

  localparam int FILL_W = calc_fill_w(DEPTH);
  localparam int PTR_W  = calc_ptr_w(DEPTH);

  if (N_INP < 1) begin : g_bad_n_inp
    $error("stream_join_sched: N_INP must be >= 1");
  end
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("stream_join_sched: DEPTH must be a power of two and >= 2");
  end

  typedef struct packed {
    logic [N_INP-1:0]   sel;
    logic [BEATS_W-1:0] beats;
  } desc_t;

  desc_t              r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FILL_W-1:0]  r_fill;
  logic [BEATS_W-1:0] r_beat_cnt;
  state_e             r_state, w_state_next;

  desc_t            w_head;
  logic             w_active, w_full, w_zero_head, w_at_last;
  logic             w_push, w_pop, w_hs, w_oup_valid;
  logic [N_INP-1:0] w_sel;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_active    = (r_state == ST_ACTIVE);
  assign w_full      = (r_fill == FILL_W'(DEPTH));
  assign w_zero_head = w_active && (w_head.sel == '0);
  assign w_at_last   = (r_beat_cnt == w_head.beats);

  // Flush and an empty FIFO both starve the join by zeroing its mask.
  assign w_sel = (w_active && !flush_i) ? w_head.sel : '0;

  stream_join_sched_join #(
    .N_INP(N_INP)
  ) u_join (
    .inp_valid_i(inp_valid_i),
    .inp_ready_o(inp_ready_o),
    .sel_i      (w_sel),
    .oup_valid_o(w_oup_valid),
    .oup_ready_i(oup_ready_i)
  );

  assign w_hs   = w_oup_valid && oup_ready_i;
  assign w_push = desc_valid_i && desc_ready_o;
  assign w_pop  = !flush_i && w_active && (w_zero_head || (w_hs && w_at_last));

  assign desc_ready_o   = !w_full && !flush_i;
  assign oup_valid_o    = w_oup_valid;
  assign oup_last_o     = w_active && w_at_last;
  assign busy_o         = w_active;
  assign fill_o         = r_fill;
  assign err_zero_sel_o = w_zero_head && !flush_i;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_push) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_pop && !w_push && r_fill == FILL_W'(1)) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    if (flush_i) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_beat_cnt <= '0;
    end else if (flush_i) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      // The pop lands exactly on the terminal count, so the counter never wraps.
      if (w_pop)      r_beat_cnt <= '0;
      else if (w_hs)  r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= '{sel: desc_sel_i, beats: desc_beats_i};
  end

endmodule

// File: tb/tb_stream_join_sched.sv
// Scoreboard bench: accepted descriptors are queued; a monitor replays them beat by beat.
module tb_stream_join_sched;

  localparam int N_INP   = 4;
  localparam int DEPTH   = 4;
  localparam int BEATS_W = 8;

  logic               clk;
  logic               rst_ni;
  logic               flush_i;
  logic [N_INP-1:0]   desc_sel_i;
  logic [BEATS_W-1:0] desc_beats_i;
  logic               desc_valid_i;
  logic               desc_ready_o;
  logic [N_INP-1:0]   inp_valid_i;
  logic [N_INP-1:0]   inp_ready_o;
  logic               oup_valid_o;
  logic               oup_ready_i;
  logic               oup_last_o;
  logic               busy_o;
  logic [2:0]         fill_o;
  logic               err_zero_sel_o;

  stream_join_sched #(
    .N_INP(N_INP), .DEPTH(DEPTH), .BEATS_W(BEATS_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .desc_sel_i    (desc_sel_i),
    .desc_beats_i  (desc_beats_i),
    .desc_valid_i  (desc_valid_i),
    .desc_ready_o  (desc_ready_o),
    .inp_valid_i   (inp_valid_i),
    .inp_ready_o   (inp_ready_o),
    .oup_valid_o   (oup_valid_o),
    .oup_ready_i   (oup_ready_i),
    .oup_last_o    (oup_last_o),
    .busy_o        (busy_o),
    .fill_o        (fill_o),
    .err_zero_sel_o(err_zero_sel_o)
  );

  typedef struct {
    logic [N_INP-1:0]   sel;
    logic [BEATS_W-1:0] beats;
    int                 cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_beats = 0;
  int   n_errs = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Acceptance side: record every descriptor handshake, stamped with its cycle.
  initial forever begin
    @(negedge clk);
    if (rst_ni && !flush_i && desc_valid_i && desc_ready_o)
      exp_q.push_back('{sel: desc_sel_i, beats: desc_beats_i, cyc: cyc});
  end

  // Monitor: a descriptor is at the head from the cycle after it was accepted.
  initial begin
    int   elig;
    int   mbeat;
    bit   hp;
    bit   ev;
    exp_t h;
    mbeat = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        exp_q.delete();
        mbeat = 0;
        continue;
      end
      elig = 0;
      foreach (exp_q[k]) if (exp_q[k].cyc < cyc) elig++;
      check("fill", 32'(fill_o), 32'(elig));
      if (flush_i) begin
        check("flush_oup_valid", 32'(oup_valid_o), 32'd0);
        check("flush_inp_ready", 32'(inp_ready_o), 32'd0);
        check("flush_desc_ready", 32'(desc_ready_o), 32'd0);
        exp_q.delete();
        mbeat = 0;
        continue;
      end
      check("desc_ready", 32'(desc_ready_o), 32'(elig < DEPTH));
      hp = (elig > 0);
      h  = hp ? exp_q[0] : '{sel: '0, beats: '0, cyc: 0};
      check("busy", 32'(busy_o), 32'(hp));
      ev = hp && (h.sel != 0) && ((inp_valid_i | ~h.sel) == {N_INP{1'b1}});
      check("oup_valid", 32'(oup_valid_o), 32'(ev));
      check("err_zero_sel", 32'(err_zero_sel_o), 32'(hp && h.sel == 0));
      if (hp && h.sel == 0) begin
        $display("zero-mask descriptor discarded at cycle %0d", cyc);
        n_errs++;
        void'(exp_q.pop_front());
      end else if (ev && oup_ready_i) begin
        check("inp_ready_beat", 32'(inp_ready_o), 32'(h.sel));
        check("oup_last", 32'(oup_last_o), 32'(mbeat == int'(h.beats)));
        $display("beat cyc=%0d sel=%b beat=%0d/%0d ready=%b last=%b",
                 cyc, h.sel, mbeat, h.beats, inp_ready_o, oup_last_o);
        n_beats++;
        if (mbeat == int'(h.beats)) begin
          void'(exp_q.pop_front());
          mbeat = 0;
        end else begin
          mbeat++;
        end
      end else begin
        check("inp_ready_idle", 32'(inp_ready_o), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_desc(input logic [N_INP-1:0] s, input logic [BEATS_W-1:0] b);
    bit ok;
    ok = 1'b0;
    desc_sel_i   = s;
    desc_beats_i = b;
    desc_valid_i = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = desc_ready_o;
      step();
    end
    desc_valid_i = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      done = !busy_o && exp_q.size() == 0;
    end
    check("drain_done", 32'(done), 32'd1);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    desc_sel_i   = '0;
    desc_beats_i = '0;
    desc_valid_i = 1'b0;
    inp_valid_i  = '0;
    oup_ready_i  = 1'b0;
    repeat (3) step();
    check("rst_fill", 32'(fill_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_oup_valid", 32'(oup_valid_o), 32'd0);
    check("rst_inp_ready", 32'(inp_ready_o), 32'd0);
    check("rst_last", 32'(oup_last_o), 32'd0);
    check("rst_err", 32'(err_zero_sel_o), 32'd0);
    check("rst_desc_ready", 32'(desc_ready_o), 32'd1);
    rst_ni = 1'b1;
    step();

    // Single descriptor, three beats.
    inp_valid_i = 4'b1111;
    oup_ready_i = 1'b1;
    push_desc(4'b0101, 8'd2);
    wait_drain(50);

    // Partial valids hold the join until every selected input is valid.
    inp_valid_i = 4'b0001;
    push_desc(4'b0011, 8'd0);
    repeat (3) step();
    inp_valid_i = 4'b0011;
    wait_drain(50);

    // Fill the FIFO under backpressure, then drain one beat per cycle.
    inp_valid_i = 4'b1111;
    oup_ready_i = 1'b0;
    push_desc(4'b0001, 8'd0);
    push_desc(4'b0010, 8'd0);
    push_desc(4'b0100, 8'd0);
    push_desc(4'b1000, 8'd0);
    @(negedge clk);
    check("full_fill", 32'(fill_o), 32'd4);
    check("full_desc_ready", 32'(desc_ready_o), 32'd0);
    step();
    oup_ready_i = 1'b1;
    wait_drain(50);

    // Zero-mask descriptor is discarded, the next one still runs.
    push_desc(4'b0000, 8'd0);
    push_desc(4'b1111, 8'd0);
    wait_drain(50);
    check("zero_err_count", 32'(n_errs), 32'd1);

    // Output backpressure keeps valid asserted and readies low.
    oup_ready_i = 1'b0;
    push_desc(4'b1111, 8'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", 32'(oup_valid_o), 32'd1);
      check("bp_inp_ready", 32'(inp_ready_o), 32'd0);
    end
    step();
    oup_ready_i = 1'b1;
    wait_drain(50);

    // Longest descriptor the counter supports.
    push_desc(4'b1010, 8'd255);
    wait_drain(400);

    // Flush after the first of four beats, with a push offered in the same cycle.
    push_desc(4'b1111, 8'd3);
    step();
    flush_i      = 1'b1;
    desc_valid_i = 1'b1;
    desc_sel_i   = 4'b0001;
    desc_beats_i = 8'd0;
    step();
    flush_i      = 1'b0;
    desc_valid_i = 1'b0;
    @(negedge clk);
    check("post_flush_fill", 32'(fill_o), 32'd0);
    check("post_flush_busy", 32'(busy_o), 32'd0);
    step();

    // Asynchronous reset in the middle of a burst.
    push_desc(4'b1111, 8'd7);
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", 32'(oup_valid_o), 32'd0);
    check("async_rst_ready", 32'(inp_ready_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_fill", 32'(fill_o), 32'd0);
    check("async_rst_desc_ready", 32'(desc_ready_o), 32'd1);
    step();
    step();
    rst_ni = 1'b1;
    step();

    // Randomised traffic checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      desc_valid_i = ($urandom_range(0, 1) == 1);
      desc_sel_i   = N_INP'($urandom);
      desc_beats_i = BEATS_W'($urandom_range(0, 3));
      inp_valid_i  = N_INP'($urandom);
      oup_ready_i  = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 49) == 0);
      step();
    end
    desc_valid_i = 1'b0;
    flush_i      = 1'b0;
    inp_valid_i  = 4'b1111;
    oup_ready_i  = 1'b1;
    wait_drain(200);
    check("beats_seen_nonzero", 32'(n_beats > 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
